// File: rtl/seg_scan_driver_pkg.sv
// Shared constants, segment codes and FSM state type for the
// multiplexed four-digit seven-segment scan driver.
package seg_scan_driver_pkg;

  localparam int DIGITS    = 4;
  localparam int BCD_W     = 16;
  localparam int VALUE_W   = 14;
  localparam int MAX_VALUE = 9999;

  // Active-low cathode patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Load/busy handshake and display pins of the scan driver.
interface seg_scan_driver_if
  import seg_scan_driver_pkg::*;
  ();
  logic               load;
  logic [VALUE_W-1:0] value;
  logic               busy;
  logic [DIGITS-1:0]  an;
  logic [6:0]         seg;
  logic               dp;

  modport master (output load, value, input busy, an, seg, dp);
  modport slave  (input load, value, output busy, an, seg, dp);
endinterface

// File: rtl/seg_scan_driver_seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder with blank control.
module seg7_decoder
  import seg_scan_driver_pkg::*;
  (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver: clamps a 14-bit value to 9999,
// converts it to BCD by shift-and-add-3 and scans the digits at CLK_DIV cycles per slot.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
  #(
  parameter int CLK_DIV       = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic              ck,
  input logic              rst,
  seg_scan_driver_if.slave bus
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int SR_W  = BCD_W + VALUE_W;

  function automatic logic [VALUE_W-1:0] clamp_value(input logic [VALUE_W-1:0] v);
    return (v > VALUE_W'(MAX_VALUE)) ? VALUE_W'(MAX_VALUE) : v;
  endfunction

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_nxt;
  logic [3:0]        shcnt;
  logic [BCD_W-1:0]  disp;
  logic              busy_q;

  logic [CNT_W-1:0]  cnt;
  logic [1:0]        idx;
  logic              lit;
  logic              tick;

  logic [3:0]        cur;
  logic [BCD_W-1:0]  upper;
  logic              blank;
  logic [6:0]        seg_w;

  always_comb begin
    sr_adj = {add3(sr[SR_W-1 -: BCD_W]), sr[VALUE_W-1:0]};
    sr_nxt = {sr_adj[SR_W-2:0], 1'b0};
  end

  // Conversion FSM: 14 shift cycles, result lands in disp as busy falls
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      shcnt  <= '0;
      busy_q <= 1'b0;
      disp   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            sr     <= {{BCD_W{1'b0}}, clamp_value(bus.value)};
            shcnt  <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sr    <= sr_nxt;
          shcnt <= shcnt + 4'd1;
          if (shcnt == 4'(VALUE_W - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            disp   <= sr_nxt[SR_W-1 -: BCD_W];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tick = (cnt == CNT_W'(CLK_DIV - 1));

  // Scan prescaler and digit index; lit stays low until the first tick
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      lit <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
      lit <= 1'b1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    cur   = disp[{idx, 2'b00} +: 4];
    upper = disp >> {idx, 2'b00};
    blank = !lit || (BLANK_LEADING && (idx != 2'd0) && (upper == '0));
  end

  seg7_decoder u_dec (
    .digit (cur),
    .blank (blank),
    .seg   (seg_w)
  );

  assign bus.busy = busy_q;
  assign bus.an   = lit ? ~(4'b0001 << idx) : 4'b1111;
  assign bus.seg  = seg_w;
  assign bus.dp   = 1'b1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (leading-zero blanking on/off) checked
// every cycle against a decimal-arithmetic reference model plus table vectors.
module tb_seg_scan_driver;
  import seg_scan_driver_pkg::*;

  localparam int CD = 4;

  logic ck  = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 ck = ~ck;

  seg_scan_driver_if bus1 ();
  seg_scan_driver_if bus0 ();

  seg_scan_driver #(.CLK_DIV(CD), .BLANK_LEADING(1'b1)) dut1 (.ck(ck), .rst(rst), .bus(bus1.slave));
  seg_scan_driver #(.CLK_DIV(CD), .BLANK_LEADING(1'b0)) dut0 (.ck(ck), .rst(rst), .bus(bus0.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: cycles since reset, remaining busy cycles, decimal value shown
  int mcyc = 0, mcnt = 0, mval = 0, mdisp = 0;

  always @(posedge ck or posedge rst) begin
    if (rst) begin
      mcyc = 0; mcnt = 0; mval = 0; mdisp = 0;
    end else begin
      mcyc++;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) mdisp = mval;
      end else if (bus1.load) begin
        mval = (int'(bus1.value) > 9999) ? 9999 : int'(bus1.value);
        mcnt = 14;
      end
    end
  end

  function automatic logic [3:0] exp_an();
    if (mcyc < CD) return 4'b1111;
    return ~(4'b0001 << ((mcyc / CD) % 4));
  endfunction

  function automatic logic [6:0] exp_seg(input bit bl);
    int i, p;
    if (mcyc < CD) return 7'b1111111;
    i = (mcyc / CD) % 4;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (bl && i > 0 && mdisp < p) return 7'b1111111;
    return seg_of((mdisp / p) % 10);
  endfunction

  always @(negedge ck) begin
    chk("an_bl1",   bus1.an,   exp_an());
    chk("an_bl0",   bus0.an,   exp_an());
    chk("seg_bl1",  bus1.seg,  exp_seg(1'b1));
    chk("seg_bl0",  bus0.seg,  exp_seg(1'b0));
    chk("busy_bl1", bus1.busy, mcnt > 0);
    chk("busy_bl0", bus0.busy, mcnt > 0);
    chk("dp",       {bus1.dp, bus0.dp}, 2'b11);
    chk("an_onehot", ($countones(~bus1.an) <= 1) && ($countones(~bus0.an) <= 1), 1);
  end

  // Busy run-length monitor
  int run = 0, last_run = 0;
  always @(negedge ck) begin
    if (rst) run = 0;
    else if (bus1.busy) run++;
    else if (run > 0) begin last_run = run; run = 0; end
  end

  task automatic drive(input logic l, input logic [13:0] v);
    bus1.load = l; bus0.load = l; bus1.value = v; bus0.value = v;
  endtask

  task automatic do_load(input logic [13:0] v);
    @(negedge ck); drive(1'b1, v);
    @(negedge ck); drive(1'b0, 14'd0);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (bus1.busy && g < 40) begin @(negedge ck); g++; end
    @(negedge ck);
    chk("busy_timeout", g < 40, 1);
  endtask

  task automatic scan_capture(output logic [3:0][6:0] o1, output logic [3:0][6:0] o0);
    o1 = {4{7'h55}}; o0 = {4{7'h55}};
    repeat (24) begin
      @(negedge ck);
      for (int i = 0; i < 4; i++) begin
        if (bus1.an == ~(4'b0001 << i)) o1[i] = bus1.seg;
        if (bus0.an == ~(4'b0001 << i)) o0[i] = bus0.seg;
      end
    end
  endtask

  typedef struct {
    int               value;
    logic [3:0][6:0]  s1;
    logic [3:0][6:0]  s0;
  } vec_t;

  localparam logic [6:0] B = 7'b1111111;

  vec_t            vt[7];
  logic [3:0][6:0] o1, o0;
  logic [3:0]      anseq[5];

  initial begin
    vt[0] = '{1234,  {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                     {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
    vt[1] = '{12000, {4{7'b0000100}}, {4{7'b0000100}}};
    vt[2] = '{7,     {B, B, B, 7'b0001111},
                     {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111}};
    vt[3] = '{0,     {B, B, B, 7'b0000001}, {4{7'b0000001}}};
    vt[4] = '{1050,  {7'b1001111, 7'b0000001, 7'b0100100, 7'b0000001},
                     {7'b1001111, 7'b0000001, 7'b0100100, 7'b0000001}};
    vt[5] = '{86,    {B, B, 7'b0000000, 7'b0100000},
                     {7'b0000001, 7'b0000001, 7'b0000000, 7'b0100000}};
    vt[6] = '{16383, {4{7'b0000100}}, {4{7'b0000100}}};
    anseq[0] = 4'b1111; anseq[1] = 4'b1101; anseq[2] = 4'b1011;
    anseq[3] = 4'b0111; anseq[4] = 4'b1110;

    drive(1'b0, 14'd0);
    rst = 1'b1;
    repeat (3) @(negedge ck);
    chk("rst_an",   bus1.an,   4'b1111);
    chk("rst_seg",  bus1.seg,  7'b1111111);
    chk("rst_busy", bus1.busy, 1'b0);
    chk("rst_dp",   bus1.dp,   1'b1);
    rst = 1'b0;

    // Scan order from reset with no load
    for (int k = 1; k <= 20; k++) begin
      @(negedge ck);
      if (k < 20) begin
        chk("scan_an", bus1.an, anseq[k / 4]);
        chk("scan_seg", bus1.seg, (bus1.an == 4'b1110) ? 7'b0000001 : 7'b1111111);
      end
    end

    foreach (vt[n]) begin
      do_load(14'(vt[n].value));
      wait_idle();
      chk("busy_len", last_run, 14);
      scan_capture(o1, o0);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("vec%0d_bl1_d%0d", n, i), o1[i], vt[n].s1[i]);
        chk($sformatf("vec%0d_bl0_d%0d", n, i), o0[i], vt[n].s0[i]);
      end
    end

    // Second load five cycles into a conversion is dropped
    @(negedge ck); drive(1'b1, 14'd42);
    @(negedge ck); drive(1'b0, 14'd0);
    repeat (3) @(negedge ck);
    drive(1'b1, 14'd99);
    @(negedge ck); drive(1'b0, 14'd0);
    wait_idle();
    chk("busy_len_ignored", last_run, 14);
    scan_capture(o1, o0);
    chk("ign_d1", o1[1], 7'b1001100);
    chk("ign_d0", o1[0], 7'b0010010);
    chk("ign_d2", o1[2], B);
    chk("ign_bl0_d3", o0[3], 7'b0000001);

    // Reset during the 7th shift cycle of 5555
    do_load(14'd5555);
    repeat (6) @(negedge ck);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", bus1.busy, 1'b0);
    chk("abort_an",   bus1.an,   4'b1111);
    chk("abort_seg",  bus0.seg,  7'b1111111);
    repeat (2) @(negedge ck);
    rst = 1'b0;
    scan_capture(o1, o0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort_bl1_d%0d", i), o1[i], vt[3].s1[i]);
      chk($sformatf("abort_bl0_d%0d", i), o0[i], vt[3].s0[i]);
    end

    // Random loads, some landing during busy, checked by the model each cycle
    for (int r = 0; r < 12; r++) begin
      do_load(14'($urandom_range(0, 16383)));
      repeat ($urandom_range(0, 30)) @(negedge ck);
      if ($urandom_range(0, 3) == 0) do_load(14'($urandom_range(0, 16383)));
      repeat ($urandom_range(0, 20)) @(negedge ck);
    end
    repeat (40) @(negedge ck);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
